// File: rtl/quadrature_decoder.sv
// ---------------------------------------------------------------------------
// quadrature_decoder
//
// Turns an incremental-encoder channel pair (InA/InB) into step strobes with
// a direction bit, and keeps a saturating position count. This is the block
// between the encoder pins and the control logic. The input path is
// synchronise -> glitch filter -> 4x decode. Illegal two-bit jumps set a
// sticky error flag.
//
// Ports
//   Clk              system clock, rising edge
//   Reset            asynchronous, active-high reset
//   ClkEnable        sample enable for filter, settle counter and decoder
//   Clear            synchronous clear of Position and flags
//   InA, InB         encoder channels, asynchronous to Clk
//   Position         saturating position count
//   StepStrobe       one-cycle pulse per accepted quadrature edge
//   Direction        1 = up (A leads B), 0 = down; last step's direction
//   LimitReachedFlag last step was refused at MIN_VALUE / MAX_VALUE
//   ErrorFlag        sticky, set on an illegal two-bit transition
//
// Settle/arm FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_SETTLE | after reset: last-state tracks filtered input, no decoding
//   S_ARMED  | decoding steps and errors from filtered input
// ---------------------------------------------------------------------------
module quadrature_decoder #(
    parameter int POSITION_BIT_WIDTH = 8,
    parameter int MAX_VALUE          = 2**POSITION_BIT_WIDTH-1,
    parameter int MIN_VALUE          = 0,
    parameter int FILTER_LENGTH      = 3
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          ClkEnable,
    input  logic                          Clear,
    input  logic                          InA,
    input  logic                          InB,
    output logic [POSITION_BIT_WIDTH-1:0] Position,
    output logic                          StepStrobe,
    output logic                          Direction,
    output logic                          LimitReachedFlag,
    output logic                          ErrorFlag
);

    localparam int FCW        = $clog2(FILTER_LENGTH+1);
    localparam int SETTLE_LEN = FILTER_LENGTH + 2;
    localparam int SCW        = $clog2(SETTLE_LEN);

    localparam logic [FCW-1:0] FILT_TC    = FCW'(FILTER_LENGTH);
    localparam logic [FCW-1:0] FILT_ONE   = FCW'(1);
    localparam logic [SCW-1:0] SETTLE_TOP = SCW'(SETTLE_LEN-1);
    localparam logic [SCW-1:0] SETTLE_ONE = SCW'(1);
    localparam logic [POSITION_BIT_WIDTH-1:0] MAX_POS = POSITION_BIT_WIDTH'(MAX_VALUE);
    localparam logic [POSITION_BIT_WIDTH-1:0] MIN_POS = POSITION_BIT_WIDTH'(MIN_VALUE);
    localparam logic [POSITION_BIT_WIDTH-1:0] POS_ONE = POSITION_BIT_WIDTH'(1);

    typedef enum logic {
        S_SETTLE = 1'b0,
        S_ARMED  = 1'b1
    } state_t;

    // Bit 1 = channel A, bit 0 = channel B throughout.
    logic [1:0]          sync_a;
    logic [1:0]          sync_b;
    logic [1:0]          sync_out;
    logic [1:0]          filtered;
    logic [1:0]          filtered_nxt;
    logic [1:0][FCW-1:0] filt_cnt;
    logic [1:0][FCW-1:0] filt_cnt_nxt;
    logic [1:0]          last_q;

    state_t              state_q;
    state_t              state_d;
    logic [SCW-1:0]      settle_cnt;
    logic                armed;

    logic [1:0]          diff;
    logic                is_step;
    logic                is_err;
    logic                step_up;

    // ------------------------------------------------------------------
    // Two-flop synchronisers. They run on every clock, independent of
    // ClkEnable, so metastability settling never depends on the enable.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= {sync_a[0], InA};
            sync_b <= {sync_b[0], InB};
        end
    end

    assign sync_out = {sync_a[1], sync_b[1]};

    // ------------------------------------------------------------------
    // Glitch filter. A channel must show a new level for FILTER_LENGTH
    // consecutive enabled samples before the filtered level follows it.
    // ------------------------------------------------------------------
    always_comb begin
        filtered_nxt = filtered;
        filt_cnt_nxt = filt_cnt;
        for (int i = 0; i < 2; i++) begin
            if (ClkEnable) begin
                if (sync_out[i] == filtered[i]) begin
                    filt_cnt_nxt[i] = '0;
                end else if (filt_cnt[i] + FILT_ONE == FILT_TC) begin
                    filtered_nxt[i] = sync_out[i];
                    filt_cnt_nxt[i] = '0;
                end else begin
                    filt_cnt_nxt[i] = filt_cnt[i] + FILT_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            filtered <= 2'b00;
            filt_cnt <= '0;
        end else begin
            filtered <= filtered_nxt;
            filt_cnt <= filt_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Settle/arm FSM: state register, next-state logic, output logic.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SETTLE: if (ClkEnable && settle_cnt == '0) state_d = S_ARMED;
            S_ARMED:  state_d = S_ARMED;
            default:  state_d = S_SETTLE;
        endcase
    end

    always_comb begin
        armed = (state_q == S_ARMED);
    end

    // Settle timer counts down one per enabled edge; terminal count 0
    // falls on the SETTLE_LEN-th enabled edge after reset release.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            settle_cnt <= SETTLE_TOP;
        end else if (state_q == S_SETTLE && ClkEnable && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SETTLE_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Transition classification of {A,B}. Up order: 00->10->11->01->00.
    // ------------------------------------------------------------------
    assign diff = filtered ^ last_q;

    always_comb begin
        step_up = 1'b0;
        case ({last_q, filtered})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
            default:                                step_up = 1'b0;
        endcase
    end

    assign is_step = armed && ClkEnable && (diff == 2'b01 || diff == 2'b10);
    assign is_err  = armed && ClkEnable && (diff == 2'b11);

    // ------------------------------------------------------------------
    // Last-state, strobe, direction, flags and position.
    // Outside of armed decoding, last-state loads filtered_nxt, not
    // filtered, so a filter update landing on the same edge (power-up
    // with inputs high, or Clear) cannot show up as a step or error on
    // the next cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q           <= 2'b00;
            Position         <= MIN_POS;
            StepStrobe       <= 1'b0;
            Direction        <= 1'b0;
            LimitReachedFlag <= 1'b0;
            ErrorFlag        <= 1'b0;
        end else if (Clear) begin
            last_q           <= filtered_nxt;
            Position         <= MIN_POS;
            StepStrobe       <= 1'b0;
            LimitReachedFlag <= 1'b0;
            ErrorFlag        <= 1'b0;
        end else begin
            StepStrobe <= is_step;

            if (ClkEnable) begin
                if (armed) begin
                    last_q <= filtered;
                end else begin
                    last_q <= filtered_nxt;
                end
            end

            if (is_err) begin
                ErrorFlag <= 1'b1;
            end

            if (is_step) begin
                Direction <= step_up;
                if (step_up) begin
                    if (Position < MAX_POS) begin
                        Position         <= Position + POS_ONE;
                        LimitReachedFlag <= 1'b0;
                    end else begin
                        LimitReachedFlag <= 1'b1;
                    end
                end else begin
                    if (Position > MIN_POS) begin
                        Position         <= Position - POS_ONE;
                        LimitReachedFlag <= 1'b0;
                    end else begin
                        LimitReachedFlag <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder at default parameters. Stimulus pushes the
// expected step (cycle, direction, position, limit) into a queue; a monitor
// on the falling edge pops and compares whenever StepStrobe is high.
module tb_quadrature_decoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       ClkEnable;
    logic       Clear;
    logic       InA;
    logic       InB;
    logic [7:0] Position;
    logic       StepStrobe;
    logic       Direction;
    logic       LimitReachedFlag;
    logic       ErrorFlag;

    quadrature_decoder dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .ClkEnable        (ClkEnable),
        .Clear            (Clear),
        .InA              (InA),
        .InB              (InB),
        .Position         (Position),
        .StepStrobe       (StepStrobe),
        .Direction        (Direction),
        .LimitReachedFlag (LimitReachedFlag),
        .ErrorFlag        (ErrorFlag)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;   // -1 = timing not checked
        logic       dir;
        logic [7:0] pos;
        logic       lim;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Inputs change on the falling edge, so the first sampling rising edge
    // is cyc+1 and the strobe is seen at the falling edge after cyc+6.
    task automatic push_step(input int exp_cyc, input logic d, input int p, input logic l);
        exp_t e;
        e.cyc = exp_cyc;
        e.dir = d;
        e.pos = p[7:0];
        e.lim = l;
        sb_q.push_back(e);
    endtask

    task automatic move(input logic a, input logic b, input logic d, input int p,
                        input logic l);
        @(negedge Clk);
        InA = a;
        InB = b;
        push_step(cyc + 6, d, p, l);
        repeat (20) @(negedge Clk);
    endtask

    // Monitor
    exp_t mon_e;
    always @(negedge Clk) begin
        if (StepStrobe) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: got strobe expected none (cycle %0d pos %0d)",
                         cyc, Position);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc >= 0) check("step_cycle", cyc, mon_e.cyc);
                check("step_dir", int'(Direction), int'(mon_e.dir));
                check("step_pos", int'(Position), int'(mon_e.pos));
                check("step_lim", int'(LimitReachedFlag), int'(mon_e.lim));
            end
        end
    end

    initial begin
        Reset     = 1'b1;
        ClkEnable = 1'b1;
        Clear     = 1'b0;
        InA       = 1'b0;
        InB       = 1'b0;
        #12;
        check("rst_pos",    int'(Position), 0);
        check("rst_strobe", int'(StepStrobe), 0);
        check("rst_dir",    int'(Direction), 0);
        check("rst_lim",    int'(LimitReachedFlag), 0);
        check("rst_err",    int'(ErrorFlag), 0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);

        // 8 up edges
        for (int i = 0; i < 2; i++) begin
            move(1, 0, 1, 4*i + 1, 0);
            move(1, 1, 1, 4*i + 2, 0);
            move(0, 1, 1, 4*i + 3, 0);
            move(0, 0, 1, 4*i + 4, 0);
        end
        check("up_pos", int'(Position), 8);
        check("up_dir", int'(Direction), 1);
        check("up_lim", int'(LimitReachedFlag), 0);

        // 10 down edges from 00: last two refused at the lower bound
        move(0, 1, 0, 7, 0);
        move(1, 1, 0, 6, 0);
        move(1, 0, 0, 5, 0);
        move(0, 0, 0, 4, 0);
        move(0, 1, 0, 3, 0);
        move(1, 1, 0, 2, 0);
        move(1, 0, 0, 1, 0);
        move(0, 0, 0, 0, 0);
        move(0, 1, 0, 0, 1);
        move(1, 1, 0, 0, 1);
        check("dn_lim", int'(LimitReachedFlag), 1);
        // up from 11 goes to 01
        move(0, 1, 1, 1, 0);
        check("recover_pos", int'(Position), 1);
        check("recover_lim", int'(LimitReachedFlag), 0);

        // Glitch: 2-cycle pulse on A rejected
        @(negedge Clk);
        InA = 1'b1;
        repeat (2) @(negedge Clk);
        InA = 1'b0;
        repeat (20) @(negedge Clk);
        check("glitch2_pos", int'(Position), 1);

        // 3-cycle pulse accepted: 01->11 is down, 11->01 is up
        @(negedge Clk);
        InA = 1'b1;
        push_step(cyc + 6, 0, 0, 0);
        repeat (3) @(negedge Clk);
        InA = 1'b0;
        push_step(cyc + 6, 1, 1, 0);
        repeat (20) @(negedge Clk);
        check("glitch3_pos", int'(Position), 1);

        // Illegal transition from 00
        move(0, 0, 1, 2, 0);
        @(negedge Clk);
        InA = 1'b1;
        InB = 1'b1;
        repeat (5) @(negedge Clk);
        check("err_early", int'(ErrorFlag), 0);
        @(negedge Clk);
        check("err_set", int'(ErrorFlag), 1);
        check("err_pos", int'(Position), 2);
        repeat (10) @(negedge Clk);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        check("clr_err", int'(ErrorFlag), 0);
        check("clr_pos", int'(Position), 0);
        check("clr_lim", int'(LimitReachedFlag), 0);
        repeat (10) @(negedge Clk);

        // Sparse enable: one up step 11->01
        push_step(-1, 1, 1, 0);
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            ClkEnable = (i % 4 == 0);
            if (i == 1) InA = 1'b0;
        end
        @(negedge Clk);
        ClkEnable = 1'b1;
        repeat (5) @(negedge Clk);
        check("gated_pos", int'(Position), 1);
        check("gated_dir", int'(Direction), 1);

        // Power-up with both channels high
        @(negedge Clk);
        Reset = 1'b1;
        InA   = 1'b1;
        InB   = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (30) @(negedge Clk);
        check("pwr_err", int'(ErrorFlag), 0);
        check("pwr_pos", int'(Position), 0);
        move(0, 1, 1, 1, 0);
        move(0, 0, 1, 2, 0);
        move(1, 0, 1, 3, 0);
        move(1, 1, 1, 4, 0);
        move(0, 1, 1, 5, 0);
        check("pre_rst_pos", int'(Position), 5);

        // Asynchronous reset mid-run, checked before the next rising edge
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("async_rst_pos", int'(Position), 0);
        check("async_rst_dir", int'(Direction), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);

        check("sb_leftover", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
